fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter N, default 64, meaning datapath/PC width in bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-low reset; sampled only on clk rising edge.
REQ-004 stall_i  input  1  hazard stall; holds PC and IF/ID register.
REQ-005 flush_i  input  1  squashes IF/ID contents (bubble).
REQ-006 pcsrc_i  input  1  redirect request (taken branch) from a later stage.
REQ-007 branch_target_i  input  N  redirect target byte address.
REQ-008 imem_addr_o  output  6  word address to instruction memory, equals PC[7:2].
REQ-009 imem_q_i  input  32  instruction word returned combinationally by instruction memory.
REQ-010 if_pc_o  output  N  PC of instruction held in IF/ID.
REQ-011 if_instr_o  output  32  instruction held in IF/ID.
REQ-012 if_valid_o  output  1  IF/ID holds a real instruction.
REQ-013 halted_o  output  1  fetch is in HALT state.
REQ-014 fetch_count_o  output  16  count of valid instructions captured into IF/ID, saturating.

Function
REQ-015 FSM states FETCH and HALT; reset state FETCH.
REQ-016 Per-edge priority: reset > pcsrc_i > stall_i > normal advance.
REQ-017 FETCH, normal advance (no stall, no redirect, imem_q_i != 32'h0): IF/ID <= {PC, imem_q_i, valid=1}; PC <= PC+4.
REQ-018 Latency: word at address A appears on if_instr_o exactly one cycle after PC == A.
REQ-019 FETCH, imem_q_i == 32'h0 with no stall and no redirect: PC holds, IF/ID valid <= 0, state <= HALT.
REQ-020 pcsrc_i in any state: PC <= {branch_target_i[N-1:2], 2'b00}, IF/ID valid <= 0, state <= FETCH; stall_i ignored that cycle.
REQ-021 stall_i without pcsrc_i: PC, IF/ID and state hold; flush_i in the same cycle still clears IF/ID valid.
REQ-022 flush_i without stall or redirect: PC advances normally, but IF/ID valid <= 0 and fetch_count_o does not increment.
REQ-023 HALT: PC holds, if_valid_o = 0, halted_o = 1; only pcsrc_i or reset leaves HALT.
REQ-024 imem_addr_o = PC[7:2]; PC is full N bits, so PC 0xFC -> addr 63 and PC 0x100 -> addr 0 (wrap in memory index only).
REQ-025 PC+4 wraps modulo 2^N.
REQ-026 fetch_count_o increments only when IF/ID loads valid=1; saturates at 16'hFFFF.
REQ-027 When if_valid_o = 0, if_instr_o = 32'h0 and if_pc_o = 0.

Reset
REQ-028 reset low at a rising edge: PC = 0, state = FETCH, if_valid_o = 0, if_instr_o = 0, if_pc_o = 0, halted_o = 0, fetch_count_o = 0.
REQ-029 Reset asserted mid-stall, mid-redirect or in HALT overrides all other inputs that cycle.
REQ-030 First fetch after reset release is address 0; imem_addr_o = 0 during reset.

Structure
REQ-031 Shared package holds fetch_state_t enum (FETCH, HALT), PC_RESET = 0, INSTR_W = 32, IMEM_ADDR_W = 6, HALT_WORD = 32'h0.
REQ-032 One sub-module, if_id_reg, holds the {pc, instr, valid} pipeline register with load, hold and clear controls; the PC, FSM and counter reside in fetch_unit.
REQ-033 Instruction memory stays external; fetch_unit connects only through imem_addr_o and imem_q_i.

Verification
REQ-034 Reset, then release with memory preloaded (word0 = f8000000, word1 = f8008001) -> imem_addr_o = 0; after edge 1: if_instr_o = f8000000, if_pc_o = 0, valid = 1; after edge 2: f8008001, pc = 4, fetch_count_o = 2.
REQ-035 stall_i high for 3 cycles at PC = 8 -> PC stays 8 and IF/ID is unchanged; one cycle after release, if_pc_o = 8.
REQ-036 pcsrc_i with target 0x43 and stall_i both high -> PC = 0x40, imem_addr_o = 16, if_valid_o = 0 next cycle.
REQ-037 Run the 19-word program (word 19 = 0) -> PC freezes at 0x4C, halted_o = 1, fetch_count_o = 19; later pcsrc_i with target 0 -> FETCH resumes at addr 0.
REQ-038 Redirect to 0xFC -> imem_addr_o = 63, then PC = 0x100 and imem_addr_o = 0.
REQ-039 Assert reset while in HALT with fetch_count_o = 19 -> all outputs return to the REQ-028 values on that edge.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg
// Shared types and constants for the instruction fetch stage.
//   fetch_state_t : fetch FSM state (FETCH / HALT)
//   PC_RESET      : program counter value after reset
//   INSTR_W       : instruction word width
//   IMEM_ADDR_W   : instruction memory word-address width
//   HALT_WORD     : instruction encoding that stops fetch
//   sat_inc16     : saturating 16-bit increment
package fetch_unit_pkg;

   typedef enum logic [0:0] {
      FETCH = 1'b0,
      HALT  = 1'b1
   } fetch_state_t;

   localparam longint unsigned PC_RESET    = 64'd0;
   localparam int unsigned     INSTR_W     = 32;
   localparam int unsigned     IMEM_ADDR_W = 6;
   localparam logic [INSTR_W-1:0] HALT_WORD = 32'h0000_0000;

   // Holds at all-ones instead of wrapping back to zero.
   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      if (v == 16'hFFFF) begin
         return v;
      end
      return v + 16'd1;
   endfunction

endpackage

// File: rtl/fetch_unit_if_id_reg.sv
// if_id_reg
// IF/ID pipeline register holding {pc, instr, valid}.
// Ports:
//   clk      : clock, rising edge
//   reset    : synchronous active-low reset, zeroes all fields
//   load_i   : capture pc_i / instr_i with valid = 1
//   clear_i  : squash to a bubble (all fields zero); wins over load_i
//   pc_i     : PC of the instruction being captured
//   instr_i  : instruction being captured
//   pc_o     : held PC (0 when not valid)
//   instr_o  : held instruction (0 when not valid)
//   valid_o  : register holds a real instruction
// With neither load_i nor clear_i the contents hold (stall).
module if_id_reg
   import fetch_unit_pkg::*;
#(
   parameter int unsigned N = 64
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               load_i,
   input  logic               clear_i,
   input  logic [N-1:0]       pc_i,
   input  logic [INSTR_W-1:0] instr_i,
   output logic [N-1:0]       pc_o,
   output logic [INSTR_W-1:0] instr_o,
   output logic               valid_o
);

   logic [N-1:0]       pc_q;
   logic [INSTR_W-1:0] instr_q;
   logic               valid_q;

   // A bubble zeroes pc and instr as well, so an invalid entry always reads as 0.
   always_ff @(posedge clk) begin
      if (!reset || clear_i) begin
         pc_q    <= '0;
         instr_q <= '0;
         valid_q <= 1'b0;
      end else if (load_i) begin
         pc_q    <= pc_i;
         instr_q <= instr_i;
         valid_q <= 1'b1;
      end
   end

   assign pc_o    = pc_q;
   assign instr_o = instr_q;
   assign valid_o = valid_q;

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit
// Instruction fetch stage: PC register, FETCH/HALT state machine, IF/ID
// register and a saturating count of captured instructions. Instruction
// memory is external and answers combinationally.
// Ports:
//   clk             : clock, rising edge
//   reset           : synchronous active-low reset
//   stall_i         : hold PC, IF/ID and state
//   flush_i         : turn the IF/ID contents into a bubble
//   pcsrc_i         : redirect to branch_target_i (highest priority after reset)
//   branch_target_i : redirect byte address, low two bits ignored
//   imem_addr_o     : instruction memory word address, PC[7:2]
//   imem_q_i        : instruction word at imem_addr_o
//   if_pc_o         : PC of the instruction in IF/ID
//   if_instr_o      : instruction in IF/ID
//   if_valid_o      : IF/ID holds a real instruction
//   halted_o        : fetch has stopped on a halt word
//   fetch_count_o   : valid instructions captured, saturating at 16'hFFFF
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter int unsigned N = 64
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   stall_i,
   input  logic                   flush_i,
   input  logic                   pcsrc_i,
   input  logic [N-1:0]           branch_target_i,
   output logic [IMEM_ADDR_W-1:0] imem_addr_o,
   input  logic [INSTR_W-1:0]     imem_q_i,
   output logic [N-1:0]           if_pc_o,
   output logic [INSTR_W-1:0]     if_instr_o,
   output logic                   if_valid_o,
   output logic                   halted_o,
   output logic [15:0]            fetch_count_o
);

   fetch_state_t state_q, state_d;
   logic [N-1:0] pc_q, pc_d;
   logic [15:0]  count_q, count_d;
   logic         ifid_load;
   logic         ifid_clear;
   logic         halt_word;

   assign halt_word = (imem_q_i == HALT_WORD);

   // State register together with the PC and counter it controls.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= FETCH;
         pc_q    <= N'(PC_RESET);
         count_q <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         count_q <= count_d;
      end
   end

   // Next state: a redirect always restarts fetch; a halt word only stops
   // fetch when the stage is actually advancing.
   always_comb begin
      state_d = state_q;
      if (pcsrc_i) begin
         state_d = FETCH;
      end else if (!stall_i && (state_q == FETCH) && halt_word) begin
         state_d = HALT;
      end
   end

   // Datapath controls for the current state and inputs.
   always_comb begin
      pc_d       = pc_q;
      count_d    = count_q;
      ifid_load  = 1'b0;
      ifid_clear = 1'b0;
      if (pcsrc_i) begin
         // Masking keeps the target word-aligned.
         pc_d       = branch_target_i & ~N'(3);
         ifid_clear = 1'b1;
      end else if (stall_i) begin
         ifid_clear = flush_i;
      end else begin
         unique case (state_q)
            FETCH: begin
               if (halt_word) begin
                  ifid_clear = 1'b1;
               end else begin
                  pc_d = pc_q + N'(4);
                  if (flush_i) begin
                     ifid_clear = 1'b1;
                  end else begin
                     ifid_load = 1'b1;
                     count_d   = sat_inc16(count_q);
                  end
               end
            end
            HALT: begin
               ifid_clear = 1'b1;
            end
            default: begin
               ifid_clear = 1'b1;
            end
         endcase
      end
   end

   if_id_reg #(
      .N (N)
   ) u_if_id_reg (
      .clk     (clk),
      .reset   (reset),
      .load_i  (ifid_load),
      .clear_i (ifid_clear),
      .pc_i    (pc_q),
      .instr_i (imem_q_i),
      .pc_o    (if_pc_o),
      .instr_o (if_instr_o),
      .valid_o (if_valid_o)
   );

   assign imem_addr_o   = pc_q[7:2];
   assign halted_o      = (state_q == HALT);
   assign fetch_count_o = count_q;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

   localparam int unsigned N = 64;

   logic          clk = 1'b0;
   logic          reset;
   logic          stall_i;
   logic          flush_i;
   logic          pcsrc_i;
   logic [N-1:0]  branch_target_i;
   logic [5:0]    imem_addr_o;
   logic [31:0]   imem_q_i;
   logic [N-1:0]  if_pc_o;
   logic [31:0]   if_instr_o;
   logic          if_valid_o;
   logic          halted_o;
   logic [15:0]   fetch_count_o;

   logic [31:0]   mem [64];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   assign imem_q_i = mem[imem_addr_o];

   fetch_unit #(
      .N (N)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .stall_i         (stall_i),
      .flush_i         (flush_i),
      .pcsrc_i         (pcsrc_i),
      .branch_target_i (branch_target_i),
      .imem_addr_o     (imem_addr_o),
      .imem_q_i        (imem_q_i),
      .if_pc_o         (if_pc_o),
      .if_instr_o      (if_instr_o),
      .if_valid_o      (if_valid_o),
      .halted_o        (halted_o),
      .fetch_count_o   (fetch_count_o)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Behavioural model of the fetch stage
   logic [63:0] m_pc;
   logic [63:0] m_ipc;
   logic [31:0] m_ins;
   bit          m_valid;
   bit          m_halt;
   int          m_cnt;
   bit          m_live = 0;

   task automatic m_bubble();
      m_valid = 0;
      m_ipc   = '0;
      m_ins   = '0;
   endtask

   always @(posedge clk) begin
      logic [31:0] w;
      if (!reset) begin
         m_pc = '0; m_halt = 0; m_cnt = 0; m_live = 1;
         m_bubble();
      end else if (m_live) begin
         if (pcsrc_i) begin
            m_pc   = branch_target_i & ~64'd3;
            m_halt = 0;
            m_bubble();
         end else if (stall_i) begin
            if (flush_i) m_bubble();
         end else if (m_halt) begin
            m_bubble();
         end else begin
            w = mem[m_pc[7:2]];
            if (w == 32'h0) begin
               m_halt = 1;
               m_bubble();
            end else begin
               if (flush_i) begin
                  m_bubble();
               end else begin
                  m_ipc   = m_pc;
                  m_ins   = w;
                  m_valid = 1;
                  if (m_cnt < 65535) m_cnt = m_cnt + 1;
               end
               m_pc = m_pc + 64'd4;
            end
         end
      end
   end

   // Per-cycle comparison against the model, away from the active edge
   always @(negedge clk) begin
      if (m_live) begin
         chk("model_imem_addr", 64'(imem_addr_o), 64'(m_pc[7:2]));
         chk("model_if_pc", if_pc_o, m_ipc);
         chk("model_if_instr", 64'(if_instr_o), 64'(m_ins));
         chk("model_if_valid", 64'(if_valid_o), 64'(m_valid));
         chk("model_halted", 64'(halted_o), 64'(m_halt));
         chk("model_count", 64'(fetch_count_o), 64'(m_cnt));
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic chk_reset_values(input string tag);
      chk({tag, "_addr"}, 64'(imem_addr_o), 64'd0);
      chk({tag, "_pc"}, if_pc_o, 64'd0);
      chk({tag, "_instr"}, 64'(if_instr_o), 64'd0);
      chk({tag, "_valid"}, 64'(if_valid_o), 64'd0);
      chk({tag, "_halted"}, 64'(halted_o), 64'd0);
      chk({tag, "_count"}, 64'(fetch_count_o), 64'd0);
   endtask

   task automatic wait_halt(input int bound);
      for (int i = 0; i < bound && !halted_o; i++) tick();
      chk("halt_reached", 64'(halted_o), 64'd1);
   endtask

   initial begin
      for (int i = 0; i < 64; i++) mem[i] = 32'hf800_0000 | (32'(i) << 8) | 32'(i);
      mem[1]  = 32'hf800_8001;
      mem[19] = 32'h0;

      reset = 1'b0; stall_i = 1'b0; flush_i = 1'b0; pcsrc_i = 1'b0;
      branch_target_i = '0;
      tick();
      tick();
      chk_reset_values("reset");

      // First fetches after release
      reset = 1'b1;
      tick();
      chk("edge1_instr", 64'(if_instr_o), 64'hf800_0000);
      chk("edge1_pc", if_pc_o, 64'd0);
      chk("edge1_valid", 64'(if_valid_o), 64'd1);
      tick();
      chk("edge2_instr", 64'(if_instr_o), 64'hf800_8001);
      chk("edge2_pc", if_pc_o, 64'd4);
      chk("edge2_count", 64'(fetch_count_o), 64'd2);

      // Three-cycle stall at PC 8
      stall_i = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("stall_addr", 64'(imem_addr_o), 64'd2);
         chk("stall_if_pc", if_pc_o, 64'd4);
         chk("stall_if_instr", 64'(if_instr_o), 64'hf800_8001);
      end
      stall_i = 1'b0;
      tick();
      chk("unstall_if_pc", if_pc_o, 64'd8);
      chk("unstall_count", 64'(fetch_count_o), 64'd3);

      // Stall with flush: bubble, PC held at 0xC
      stall_i = 1'b1; flush_i = 1'b1;
      tick();
      chk("stflush_valid", 64'(if_valid_o), 64'd0);
      chk("stflush_instr", 64'(if_instr_o), 64'd0);
      chk("stflush_addr", 64'(imem_addr_o), 64'd3);

      // Flush alone: PC advances, no count
      stall_i = 1'b0;
      tick();
      chk("flush_addr", 64'(imem_addr_o), 64'd4);
      chk("flush_count", 64'(fetch_count_o), 64'd3);
      flush_i = 1'b0;

      // Redirect wins over stall, target aligned
      pcsrc_i = 1'b1; stall_i = 1'b1; branch_target_i = 64'h43;
      tick();
      chk("redir_addr", 64'(imem_addr_o), 64'd16);
      chk("redir_valid", 64'(if_valid_o), 64'd0);
      pcsrc_i = 1'b0; stall_i = 1'b0;
      wait_halt(10);
      chk("halt1_addr", 64'(imem_addr_o), 64'd19);
      chk("halt1_count", 64'(fetch_count_o), 64'd6);
      tick();
      tick();
      chk("halt1_hold_addr", 64'(imem_addr_o), 64'd19);

      // Reset overrides stall and redirect
      reset = 1'b0; stall_i = 1'b1; pcsrc_i = 1'b1; branch_target_i = 64'h80;
      tick();
      chk_reset_values("rst_over");
      reset = 1'b1; stall_i = 1'b0; pcsrc_i = 1'b0;

      // Full program to halt
      wait_halt(40);
      chk("prog_count", 64'(fetch_count_o), 64'd19);
      chk("prog_addr", 64'(imem_addr_o), 64'd19);
      chk("prog_if_valid", 64'(if_valid_o), 64'd0);

      // Reset while halted
      reset = 1'b0;
      tick();
      chk_reset_values("rst_halt");
      reset = 1'b1;
      wait_halt(40);
      chk("prog2_count", 64'(fetch_count_o), 64'd19);

      // Redirect out of HALT
      pcsrc_i = 1'b1; branch_target_i = 64'h0;
      tick();
      chk("resume_addr", 64'(imem_addr_o), 64'd0);
      chk("resume_halted", 64'(halted_o), 64'd0);
      pcsrc_i = 1'b0;
      tick();
      chk("resume_instr", 64'(if_instr_o), 64'hf800_0000);
      chk("resume_count", 64'(fetch_count_o), 64'd20);

      // Memory index wrap
      pcsrc_i = 1'b1; branch_target_i = 64'hFC;
      tick();
      chk("wrap_addr63", 64'(imem_addr_o), 64'd63);
      pcsrc_i = 1'b0;
      tick();
      chk("wrap_addr0", 64'(imem_addr_o), 64'd0);
      chk("wrap_if_pc", if_pc_o, 64'hFC);

      // Full-width PC wrap
      pcsrc_i = 1'b1; branch_target_i = 64'hFFFF_FFFF_FFFF_FFFF;
      tick();
      chk("pcwrap_addr", 64'(imem_addr_o), 64'd63);
      pcsrc_i = 1'b0;
      tick();
      chk("pcwrap_if_pc", if_pc_o, 64'hFFFF_FFFF_FFFF_FFFC);
      chk("pcwrap_addr0", 64'(imem_addr_o), 64'd0);
      tick();
      tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
